tns_dec_arbiter: RTL and testbench
==================================

Name: tns_dec_arbiter

Overview:
- Round-robin arbiter and output pipeline that lets NREQ receive lanes share one 19-bit TNS decoder.
- The decoder is the team's combinational 19-bit TNS codeword-to-binary decoder, with weights TNS01_C..TNS07_C from TNS.vh.
- Sits on the receive side of the 3C1S TSV link, after lane deskew and before the data sink.
- Each cycle it grants at most one valid lane, decodes that lane's codeword and registers the result with the lane ID. The output stage uses a valid/ready handshake.

Parameters:
- NREQ, 4, number of requesting lanes; legal range 2..16.
- IDW, 2, width of the lane ID; must satisfy 2^IDW >= NREQ.
- DW, `BLEN07_C, width of the decoded data; must equal the decoder output width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  arbitration enable; when low, no new grants are issued.
- req_valid  input  NREQ  per-lane codeword valid.
- req_code  input  NREQ*19  per-lane codewords; lane i occupies bits [19*i+18 : 19*i].
- req_ready  output  NREQ  one-hot grant; lane i is accepted when req_valid[i] and req_ready[i] are both high.
- out_valid  output  1  output register holds a decoded word.
- out_data  output  DW  decoded binary value.
- out_id  output  IDW  lane index that produced out_data.
- out_ready  input  1  downstream accepts the output when out_valid and out_ready are both high.
- busy  output  1  out_valid OR any req_valid.

Behaviour:
- Reset values (asynchronous): out_valid=0, out_data=0, out_id=0, round-robin pointer rr_ptr=0.
- Combinational outputs during reset: req_ready=0, busy=0.
- Free slot: can_accept = en AND (NOT out_valid OR out_ready).
- Grant:
  - When can_accept is high, grant goes to the first lane with req_valid high, searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - req_ready is one-hot on that lane, and all-zero if no lane is valid or can_accept is low.
  - req_ready is combinational from req_valid, rr_ptr, en, out_valid and out_ready. It must never depend on req_code.
- Accept: on an edge where a grant to lane g occurs:
  - out_data <= decode(req_code lane g).
  - out_id <= g.
  - out_valid <= 1.
  - rr_ptr <= (g+1) mod NREQ.
- Latency: exactly 1 clock from acceptance to out_valid high. Sustained throughput is 1 word per clock while out_ready=1.
- Drain without new grant: if out_valid and out_ready are high and no grant occurs, out_valid <= 0. out_data and out_id keep their last values.
- Simultaneous drain and accept: the new word replaces the old one in the same edge and out_valid stays 1 (no bubble).
- Stall: while out_valid=1 and out_ready=0, out_data, out_id and out_valid hold, req_ready is all-zero, and rr_ptr holds.
- rr_ptr changes only on a grant. Idle cycles and en=0 do not move it.
- en low:
  - No new grants.
  - A pending output still drains normally.
  - Deasserting en mid-stall is legal.
- Decode arithmetic:
  - Unsigned sum of codeword bit k times weight k, per the TNS.vh mapping: bit0=TNS01_C, bit1=TNS01_B, bit2=TNS01_A, bit3=TNS02_C, ..., bit17=TNS06_A, bit18=TNS07_C.
  - The sum is truncated to DW bits.
  - No codeword legality check; illegal 3C1S codewords decode arithmetically.
- Reset mid-operation: a pending output is discarded and the grant pattern restarts at lane 0.
- Out-of-range rr_ptr (NREQ not a power of 2) cannot occur because it is updated modulo NREQ.
- Fairness: a lane with req_valid held high is granted within NREQ accepting cycles.

Test Plan:
- Reset then idle with all req_valid=0 -> out_valid=0, req_ready=0, busy=0, out_data=0.
- Lane 2 only, req_code=19'h00001, out_ready=1 -> req_ready=4'b0100 for 1 cycle; next cycle out_valid=1, out_id=2, out_data=TNS01_C. Repeat with 19'h40000 -> out_data=TNS07_C; with 19'h00000 -> out_data=0.
- All 4 lanes valid, out_ready=1, en=1 for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3; out_valid continuously high; out_id sequence lagging grants by 1 cycle.
- Lane 1 accepted, then out_ready=0 for 3 cycles with lanes 0 and 3 valid -> out_data/out_id held, req_ready=0000, rr_ptr=2; on out_ready=1 -> lane 3 granted in the same cycle as the drain, out_valid stays 1.
- en=0 with lanes valid and one output pending -> pending output drains on out_ready, no further grants, out_valid falls to 0; en=1 -> grants resume from the unchanged rr_ptr.
- Assert rst while out_valid=1 mid-stream -> out_valid=0 immediately (asynchronous); after release, the first grant goes to the lowest valid lane starting from 0.

Source files
------------

// File: rtl/tns_dec_arbiter.sv
// Round-robin arbiter sharing one combinational 19-bit TNS decoder among
// NREQ receive lanes. The decoded word is registered with its lane ID and
// leaves through a valid/ready output stage.
module tns_dec_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int DW   = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*19-1:0]   req_code,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [IDW-1:0]       out_id,
  input  logic                 out_ready,
  output logic                 busy
);

  // TNS weights for codeword bits 0..18 (TNS01_C, TNS01_B, TNS01_A, ..., TNS07_C).
  localparam logic [31:0] TNS_W [19] = '{
    32'd1,     32'd2,     32'd4,     32'd7,     32'd13,
    32'd24,    32'd44,    32'd81,    32'd149,   32'd274,
    32'd504,   32'd927,   32'd1705,  32'd3136,  32'd5768,
    32'd10609, 32'd19513, 32'd35890, 32'd66012
  };

  logic [IDW-1:0]   rr_ptr;
  logic             can_accept;
  logic             grant;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   nxt_ptr;
  logic [18:0]      lane_code;
  logic [DW-1:0]    dec_data;

  // Unsigned weighted sum of codeword bits, truncated to DW; no legality check.
  function automatic logic [DW-1:0] tns_decode(input logic [18:0] cw);
    logic [31:0] acc;
    acc = '0;
    for (int unsigned k = 0; k < 19; k++) begin
      if (cw[k]) acc = acc + TNS_W[k];
    end
    return acc[DW-1:0];
  endfunction

  // Output slot is free when enabled and the register is empty or draining.
  always_comb begin
    can_accept = en && (!out_valid || out_ready);
  end

  // Search upward from rr_ptr with wrap for the first valid lane; req_code is not consulted.
  always_comb begin
    int unsigned idx;
    int unsigned sel;
    logic        found;
    found = 1'b0;
    sel   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_ptr) + i) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    grant     = found && can_accept && !rst;
    gnt_id    = IDW'(sel);
    nxt_ptr   = IDW'((sel + 1) % NREQ);
    req_ready = '0;
    if (grant) req_ready[sel] = 1'b1;
  end

  // Decode the granted lane's codeword.
  always_comb begin
    lane_code = req_code[32'(gnt_id)*19 +: 19];
    dec_data  = tns_decode(lane_code);
  end

  // Activity flag, forced low while reset is applied.
  always_comb begin
    busy = !rst && (out_valid || (|req_valid));
  end

  // Output register and round-robin pointer; a grant overrides a drain so there is no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= dec_data;
      out_id    <= gnt_id;
      rr_ptr    <= nxt_ptr;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tns_dec_arbiter.sv
// Self-checking bench for tns_dec_arbiter: directed scenarios followed by
// randomized traffic, compared against a transaction-level reference model.
module tb_tns_dec_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int DW   = 18;

  logic               clk;
  logic               rst;
  logic               en;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*19-1:0] req_code;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [IDW-1:0]     out_id;
  logic               out_ready;
  logic               busy;

  int vectors;
  int miscompares;

  // Reference model state
  logic [31:0] w [19];
  bit          m_valid;
  int          m_data;
  int          m_id;
  int          m_ptr;

  tns_dec_arbiter #(.NREQ(NREQ), .IDW(IDW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_code(req_code),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .out_ready(out_ready), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_decode(input logic [18:0] cw);
    longint s;
    s = 0;
    for (int k = 0; k < 19; k++) if (cw[k]) s += w[k];
    return int'(s % (longint'(1) << DW));
  endfunction

  // Lane that the arbitration rules select this cycle, or -1.
  function automatic int model_grant(input logic e, input logic [NREQ-1:0] v, input logic ordy);
    if (!(e && (!m_valid || ordy))) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (m_ptr + k) % NREQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 0;
    m_id    = 0;
    m_ptr   = 0;
  endtask

  // One clock: drive after the previous edge, check combinational outputs,
  // advance the model across the edge, then check registered outputs.
  task automatic step(input logic e, input logic [NREQ-1:0] v,
                      input logic [NREQ*19-1:0] code, input logic ordy);
    int g;
    en = e; req_valid = v; req_code = code; out_ready = ordy;
    #2;
    g = model_grant(e, v, ordy);
    chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    chk("busy", 32'(busy), 32'(m_valid || (|v)));
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = model_decode(code[g*19 +: 19]);
      m_id    = g;
      m_ptr   = (g + 1) % NREQ;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_id", 32'(out_id), 32'(m_id));
  endtask

  function automatic logic [NREQ*19-1:0] lane_codes(input logic [18:0] c0, input logic [18:0] c1,
                                                     input logic [18:0] c2, input logic [18:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  initial begin
    logic [NREQ*19-1:0] rc;
    vectors = 0;
    miscompares = 0;
    // Tribonacci weights seeded 1,2,4
    w[0] = 1; w[1] = 2; w[2] = 4;
    for (int k = 3; k < 19; k++) w[k] = w[k-1] + w[k-2] + w[k-3];
    model_reset();

    rst = 1'b1; en = 1'b0; req_valid = '0; req_code = '0; out_ready = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Idle after reset
    step(1, 4'b0000, '0, 1);
    step(1, 4'b0000, '0, 1);

    // Lane 2 alone: TNS01_C, TNS07_C, zero codeword
    step(1, 4'b0100, lane_codes(0, 0, 19'h00001, 0), 1);
    chk("dir_tns01c", 32'(out_data), 32'd1);
    chk("dir_id2", 32'(out_id), 32'd2);
    step(1, 4'b0100, lane_codes(0, 0, 19'h40000, 0), 1);
    chk("dir_tns07c", 32'(out_data), 32'd66012);
    step(1, 4'b0100, lane_codes(0, 0, 19'h00000, 0), 1);
    chk("dir_zero", 32'(out_data), 32'd0);
    step(1, 4'b0000, '0, 1);

    // All lanes valid for 8 cycles: rotation 0,1,2,3 (pointer resumes at 3 after lane 2)
    for (int i = 0; i < 8; i++)
      step(1, 4'b1111, lane_codes(19'(i), 19'(i + 8), 19'(i + 16), 19'(i + 24)), 1);
    step(1, 4'b0000, '0, 1);

    // Fresh reset so the stall scenario starts from pointer 0
    rst = 1'b1; #1; model_reset(); @(posedge clk); #1; rst = 1'b0;

    // Lane 1 accepted, then 3-cycle stall with lanes 0 and 3 waiting
    rc = lane_codes(19'h00011, 19'h00003, 0, 19'h00700);
    step(1, 4'b0010, rc, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 4'b1001, rc, 0);
      chk("stall_id", 32'(out_id), 32'd1);
    end
    step(1, 4'b1001, rc, 1);
    chk("drain_accept_id", 32'(out_id), 32'd3);
    chk("drain_accept_valid", 32'(out_valid), 32'd1);

    // en low with a pending output: drain, no grants; then resume
    step(0, 4'b1111, rc, 0);
    step(0, 4'b1111, rc, 1);
    chk("en0_drained", 32'(out_valid), 32'd0);
    step(0, 4'b1111, rc, 1);
    step(1, 4'b1111, rc, 1);
    chk("resume_id", 32'(out_id), 32'd0);

    // Asynchronous reset mid-stream
    step(1, 4'b1111, rc, 1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    chk("async_rst_ready", 32'(req_ready), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1, 4'b1010, rc, 1);
    chk("post_rst_id", 32'(out_id), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [NREQ*19-1:0] r;
      for (int l = 0; l < NREQ; l++) r[l*19 +: 19] = 19'($urandom);
      step(($urandom_range(0, 7) != 0), 4'($urandom), r, ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
